clk_divider_multi: RTL and testbench

Parametrised, multi-channel successor to the fixed 1 Hz divider. N_CH independent channels each derive a square-wave clock-enable level (clk_out) and a one-cycle strobe (tick) from clk_in. Each channel has a runtime-programmable half-period, a per-channel enable, and glitch-free divisor reload. A global sync_start re-aligns the phase of all channels. Feeds display multiplexers, debouncers and blinkers as logic signals; never used as a real clock net.

---
 rtl/clk_div_pkg.sv | 27 ++
 rtl/clk_div_channel.sv | 86 ++++++++
 rtl/clk_divider_multi.sv | 59 +++++
 tb/tb_clk_divider_multi.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock-enable divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEFAULT          = 26;
  localparam int unsigned DEFAULT_DIV_1HZ_100MHZ = 50_000_000;

  typedef logic [CNT_W_DEFAULT-1:0] div_t;

  // Per-cycle action chosen for a channel, in decreasing priority.
  typedef enum logic [2:0] {
    ACT_SYNC,
    ACT_OFF,
    ACT_FROZEN,
    ACT_TERM,
    ACT_CLAMP,
    ACT_COUNT
  } ch_act_e;

  // Channel-select width; never less than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n_ch);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n_ch) w++;
    return w;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, output level, strobe and the
// pending/active divisor pair that makes reloads glitch-free.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_1HZ_100MHZ
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             clk_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  ch_act_e          sel;

  always_comb begin
    pend_d = we_i ? div_i : pend_q;
    if (sync_i)                   sel = ACT_SYNC;
    else if (!en_i)               sel = ACT_OFF;
    else if (act_q == '0)         sel = ACT_FROZEN;
    else if (cnt_q == act_q - ONE) sel = ACT_TERM;
    else if (cnt_q >= act_q)      sel = ACT_CLAMP;
    else                          sel = ACT_COUNT;
  end

  // Reloads read pend_d so a write landing on a reload cycle takes effect at once.
  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    act_d  = act_q;
    unique case (sel)
      ACT_SYNC, ACT_OFF: begin
        cnt_d = '0;
        clk_d = 1'b0;
        act_d = pend_d;
      end
      ACT_FROZEN: begin
        cnt_d = '0;
        act_d = pend_d;
      end
      ACT_TERM: begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = 1'b1;
        act_d  = pend_d;
      end
      ACT_CLAMP: cnt_d = '0;
      ACT_COUNT: cnt_d = cnt_q + ONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      act_q  <= RST_DIV;
      pend_q <= RST_DIV;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      act_q  <= act_d;
      pend_q <= pend_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_divider_multi.sv
// N_CH-channel clock-enable divider: configuration decode, cfg_err flag and
// one clk_div_channel per channel.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_1HZ_100MHZ
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [N_CH-1:0]           en,
  input  logic                      sync_start,
  input  logic                      cfg_we,
  input  logic [ch_idx_w(N_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_div,
  output logic                      cfg_err,
  output logic [N_CH-1:0]           clk_out,
  output logic [N_CH-1:0]           tick
);

  localparam int unsigned   CHW   = ch_idx_w(N_CH);
  localparam logic [CHW:0]  NCH_L = (CHW + 1)'(N_CH);

  logic [N_CH-1:0] we_vec;
  logic            cfg_err_q, cfg_err_d;

  always_comb begin
    we_vec = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      we_vec[c] = cfg_we && (cfg_ch == CHW'(c));
    end
    cfg_err_d = cfg_we && ({1'b0, cfg_ch} >= NCH_L);
  end

  always_ff @(posedge clk_in) begin
    if (reset) cfg_err_q <= 1'b0;
    else       cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_i (clk_in),
      .rst_i (reset),
      .en_i  (en[g]),
      .sync_i(sync_start),
      .we_i  (we_vec[g]),
      .div_i (cfg_div),
      .clk_o (clk_out[g]),
      .tick_o(tick[g])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi (N_CH=3, CNT_W=8, DEFAULT_DIV=4).
module tb_clk_divider_multi;

  logic       clk_in;
  logic       reset;
  logic [2:0] en;
  logic       sync_start;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_err;
  logic [2:0] clk_out;
  logic [2:0] tick;

  clk_divider_multi #(
    .N_CH       (3),
    .CNT_W      (8),
    .DEFAULT_DIV(4)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .en        (en),
    .sync_start(sync_start),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: per-channel elapsed count within the half-period,
  // output level, and the divisor in force / waiting.
  int         m_cnt [3];
  int         m_act [3];
  int         m_pend[3];
  logic [2:0] m_clk;
  logic [2:0] m_tick;
  logic       m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [2:0] e, input logic s,
                            input logic we, input logic [1:0] ch, input logic [7:0] d);
    m_err = !r && we && (int'(ch) >= 3);
    for (int c = 0; c < 3; c++) begin
      int np;
      np = (we && int'(ch) == c) ? int'(d) : m_pend[c];
      if (r) begin
        m_cnt[c] = 0; m_clk[c] = 1'b0; m_tick[c] = 1'b0; m_act[c] = 4; m_pend[c] = 4;
      end else begin
        m_tick[c] = 1'b0;
        if (s || !e[c]) begin
          m_cnt[c] = 0; m_clk[c] = 1'b0; m_act[c] = np;
        end else if (m_act[c] == 0) begin
          m_cnt[c] = 0; m_act[c] = np;
        end else if (m_cnt[c] + 1 == m_act[c]) begin
          m_cnt[c] = 0; m_clk[c] = ~m_clk[c]; m_tick[c] = 1'b1; m_act[c] = np;
        end else if (m_cnt[c] >= m_act[c]) begin
          m_cnt[c] = 0;
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
        m_pend[c] = np;
      end
    end
  endtask

  task automatic step(input logic r, input logic [2:0] e, input logic s,
                      input logic we, input logic [1:0] ch, input logic [7:0] d);
    reset = r; en = e; sync_start = s; cfg_we = we; cfg_ch = ch; cfg_div = d;
    @(posedge clk_in);
    model_step(r, e, s, we, ch, d);
    #1;
    chk("model", {25'd0, clk_out, tick, cfg_err}, {25'd0, m_clk, m_tick, m_err});
  endtask

  task automatic run(input int n, input logic [2:0] e);
    for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] en;
    logic       sync;
    logic       we;
    logic [1:0] ch;
    logic [7:0] div;
    logic [2:0] e_clk;
    logic [2:0] e_tick;
    logic       e_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [2:0] prev;
    int         j;
    logic [2:0] e;
    logic [1:0] ch;
    logic [7:0] d;

    reset = 1'b1; en = '0; sync_start = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;

    vecs[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 1'b0};
    vecs[1]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 1'b0};
    vecs[2]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 1'b0};
    vecs[3]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 1'b0};
    vecs[4]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 1'b0};
    vecs[5]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000, 1'b0};
    vecs[6]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000, 1'b0};
    vecs[7]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000, 1'b0};
    vecs[8]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b111, 1'b0};
    vecs[9]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 1'b0};
    vecs[10] = '{1'b0, 3'b111, 1'b0, 1'b1, 2'd3, 8'd9, 3'b000, 3'b000, 1'b1};
    vecs[11] = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 1'b0};
    vecs[12] = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 1'b0};

    // Reset, free-running default divisor, out-of-range write.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].sync, vecs[i].we, vecs[i].ch, vecs[i].div);
      chk("table", {25'd0, clk_out, tick, cfg_err},
          {25'd0, vecs[i].e_clk, vecs[i].e_tick, vecs[i].e_err});
    end

    // Reload mid half-period: current half still 4 cycles, then 2.
    step(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b0, 3'b111, 1'b0, 1'b1, 2'd0, 8'd2);
    step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("reload_hold", {31'd0, clk_out[0]}, 32'd0);
    step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("reload_first_rise", {31'd0, clk_out[0]}, 32'd1);
    step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("reload_short_hi", {31'd0, clk_out[0]}, 32'd1);
    step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("reload_short_fall", {31'd0, clk_out[0]}, 32'd0);

    // D=1 then D=0 on channel 1.
    step(1'b0, 3'b111, 1'b0, 1'b1, 2'd1, 8'd1);
    run(5, 3'b111);
    prev = clk_out;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
      chk("d1_tick", {31'd0, tick[1]}, 32'd1);
      chk("d1_toggle", {31'd0, clk_out[1]}, {31'd0, ~prev[1]});
      prev = clk_out;
    end
    step(1'b0, 3'b111, 1'b0, 1'b1, 2'd1, 8'd0);
    step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
    prev = clk_out;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
      chk("d0_freeze", {30'd0, clk_out[1], tick[1]}, {30'd0, prev[1], 1'b0});
    end

    // Phase alignment by sync_start, then sync on a terminal-count cycle.
    step(1'b0, 3'b111, 1'b0, 1'b1, 2'd0, 8'd3);
    step(1'b0, 3'b111, 1'b0, 1'b1, 2'd1, 8'd5);
    step(1'b0, 3'b111, 1'b0, 1'b1, 2'd2, 8'd3);
    run(10, 3'b111);
    step(1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0);
    chk("sync_clear", {26'd0, clk_out, tick}, 32'd0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
      chk("sync_align0", {31'd0, tick[0]}, {31'd0, (i % 3) == 0});
      chk("sync_align2", {31'd0, tick[2]}, {31'd0, (i % 3) == 0});
    end
    run(2, 3'b111);
    step(1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 8'd0);
    chk("sync_on_tc", {26'd0, clk_out, tick}, 32'd0);

    // Disable, reprogram, re-enable channel 2.
    run(2, 3'b111);
    step(1'b0, 3'b011, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("dis_low", {31'd0, clk_out[2]}, 32'd0);
    step(1'b0, 3'b011, 1'b0, 1'b1, 2'd2, 8'd6);
    step(1'b0, 3'b011, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("dis_low2", {31'd0, clk_out[2]}, 32'd0);
    j = 1;
    while (j <= 20) begin
      step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
      if (clk_out[2]) break;
      j++;
    end
    chk("reenable_rise", j, 6);

    // Reset mid-count restores the default divisor.
    run(3, 3'b111);
    step(1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
    chk("reset_clear", {25'd0, clk_out, tick, cfg_err}, 32'd0);
    j = 1;
    while (j <= 20) begin
      step(1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
      if (clk_out[0]) break;
      j++;
    end
    chk("reset_div", j, 4);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      e = 3'b111;
      if ($urandom_range(0, 9) == 0) e = 3'($urandom);
      ch = 2'($urandom);
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 7));
      step($urandom_range(0, 299) == 0, e, $urandom_range(0, 49) == 0,
           $urandom_range(0, 5) == 0, ch, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
